add_serial_param: RTL

//   Parametrised multi-bit serial adder: the next generation of the 1-bit serial add datapath.

---
 rtl/add_serial_param.sv | 132 +++++++++++++
 1 files changed

// File: rtl/add_serial_param.sv
// Serial adder: latches two WIDTH-bit operands and adds DIGIT bits per cycle, LSB first.
// Optional subtract mode is enabled by defining ADD_SERIAL_SUB_EN.
module add_serial_param #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] out,
    output logic             cout,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CW-1:0]    count_q, count_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0] b_eff;
    logic             c0;
    logic [DIGIT:0]   s;
    logic [WIDTH-1:0] res_shift;
    logic             last;

`ifdef ADD_SERIAL_SUB_EN
    assign b_eff = sub ? ~b : b;
    assign c0    = sub;
`else
    logic sub_unused;
    assign sub_unused = sub;
    assign b_eff      = b;
    assign c0         = 1'b0;
`endif

    assign s    = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
    assign last = (count_q == CW'(N - 1));

    // Result digits enter at the MSB end so the final digit lands at the top.
    generate
        if (DIGIT == WIDTH) begin : g_single
            assign res_shift = s[DIGIT-1:0];
        end else begin : g_multi
            assign res_shift = {s[DIGIT-1:0], res_q[WIDTH-1:DIGIT]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            count_q <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            count_q <= count_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        count_d = count_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE, DONE: begin
                if (en) begin
                    a_d     = a;
                    b_d     = b_eff;
                    res_d   = '0;
                    count_d = '0;
                    carry_d = c0;
                    state_d = ADD;
                end
            end
            ADD: begin
                res_d   = res_shift;
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                carry_d = s[DIGIT];
                count_d = count_q + CW'(1);
                if (last) begin
                    cout_d  = s[DIGIT];
                    // b_q already holds the inverted operand when subtracting.
                    ovf_d   = (a_q[DIGIT-1] == b_q[DIGIT-1]) & (s[DIGIT-1] != a_q[DIGIT-1]);
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Partial digits stay hidden so the result reads zero until it is complete.
    assign out  = (state_q == DONE) ? res_q : '0;
    assign cout = cout_q;
    assign ovf  = ovf_q;
    assign busy = (state_q == ADD);
    assign done = (state_q == DONE);

endmodule
